// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, instruction field positions and the
// one-hot encoding of the fetch state machine.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_REQ   = 5'b00010,
    S_WAIT  = 5'b00100,
    S_DONE  = 5'b01000,
    S_DRAIN = 5'b10000
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read channel: valid/ready request, valid-only response.
interface instr_fetch_if #(
  parameter int WIDTH = 32
);
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_rsp_valid;
  logic [WIDTH-1:0] mem_rsp_data;

  modport master (
    output mem_req_valid, mem_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/instr_fields.sv
// Pure combinational slicer from an instruction word to its MIPS fields.
module instr_fields
  import mips_pkg::*;
(
  input  logic [31:0] ir,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm
);

  assign op    = ir[OP_MSB:OP_LSB];
  assign funct = ir[FUNCT_MSB:FUNCT_LSB];
  assign rs    = ir[RS_MSB:RS_LSB];
  assign rt    = ir[RT_MSB:RT_LSB];
  assign rd    = ir[RD_MSB:RD_LSB];
  assign imm   = ir[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/instr_fetch.sv
// Multicycle instruction fetch: one word read per fetch_req, result held in
// the IR and sliced into decoder fields. Outputs come only from registers.
//
//   state   | meaning
//   IDLE    | waiting for fetch_req
//   REQ     | request presented, waiting for mem_req_ready
//   WAIT    | request accepted, waiting for the response
//   DONE    | IR just written, instr_valid high
//   DRAIN   | flushed after acceptance, discarding the response
module instr_fetch
  import mips_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_IR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fetch_req,
  input  logic [WIDTH-1:0] pc,
  input  logic             flush,
  instr_fetch_if.master    mem,
  output logic [WIDTH-1:0] instr,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [15:0]      imm,
  output logic             instr_valid,
  output logic             busy,
  output logic             err
);

  fetch_state_t     state, state_nxt;
  logic [WIDTH-1:0] ir;
  logic [WIDTH-1:0] addr_q;
  logic             err_q;
  logic             load_addr;
  logic             load_ir;
  logic             err_set;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and datapath strobes; flush outranks ready and response
  always_comb begin
    state_nxt = state;
    load_addr = 1'b0;
    load_ir   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fetch_req) begin
          load_addr = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (flush)                  state_nxt = S_IDLE;
        else if (mem.mem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem.mem_rsp_valid) begin
          if (flush) begin
            state_nxt = S_IDLE;
          end else begin
            load_ir   = 1'b1;
            state_nxt = S_DONE;
          end
        end else if (flush) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_DRAIN: if (mem.mem_rsp_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A response is only legal while one is outstanding; unaligned PCs are flagged but still fetched
  always_comb begin
    err_set = (mem.mem_rsp_valid && (state == S_IDLE || state == S_REQ || state == S_DONE))
              || (load_addr && (pc[1:0] != 2'b00));
  end

  // Address register, instruction register and sticky error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      ir     <= WIDTH'(RESET_IR);
      err_q  <= 1'b0;
    end else begin
      if (load_addr) addr_q <= pc;
      if (load_ir)   ir     <= mem.mem_rsp_data;
      if (err_set)   err_q  <= 1'b1;
    end
  end

  assign mem.mem_req_valid = (state == S_REQ);
  assign mem.mem_addr      = addr_q;
  assign instr             = ir;
  assign instr_valid       = (state == S_DONE);
  assign busy              = (state != S_IDLE);
  assign err               = err_q;

  instr_fields u_fields (
    .ir    (ir[31:0]),
    .op    (op),
    .funct (funct),
    .rs    (rs),
    .rt    (rt),
    .rd    (rd),
    .imm   (imm)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: table of fetches with expected decoded fields fed
// through a scoreboard queue, plus hand-written flush/error/reset sequences.
module tb_instr_fetch;
  import mips_pkg::*;

  localparam logic [31:0] RESET_IR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_req;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        instr_valid, busy, err;

  instr_fetch_if #(.WIDTH(32)) mem ();

  instr_fetch #(.WIDTH(32), .RESET_IR(RESET_IR)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fetch_req   (fetch_req),
    .pc          (pc),
    .flush       (flush),
    .mem         (mem),
    .instr       (instr),
    .op          (op),
    .funct       (funct),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .imm         (imm),
    .instr_valid (instr_valid),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          rdy_dly;
    int          rsp_dly;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
  } vec_t;

  vec_t vecs[6];
  vec_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   iv_count  = 0;
  int   hs_count  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every instr_valid pulse must match the oldest pending fetch
  always @(negedge clk) begin
    vec_t e;
    if (mem.mem_req_valid === 1'b1 && mem.mem_req_ready === 1'b1) hs_count++;
    if (instr_valid === 1'b1) begin
      iv_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_instr_valid", 32'(instr_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("instr", instr, e.data);
        check("op", 32'(op), 32'(e.op));
        check("rs", 32'(rs), 32'(e.rs));
        check("rt", 32'(rt), 32'(e.rt));
        check("rd", 32'(rd), 32'(e.rd));
        check("funct", 32'(funct), 32'(e.funct));
        check("imm", 32'(imm), 32'(e.imm));
      end
    end
  end

  // One complete fetch; entered in an IDLE cycle, returns at the negedge of the following IDLE cycle
  task automatic do_fetch(input vec_t v);
    int iv0;
    int hs0;
    iv0 = iv_count;
    hs0 = hs_count;
    fetch_req = 1'b1;
    pc        = v.pc;
    step();
    fetch_req = 1'b0;
    for (int i = 0; i < v.rdy_dly; i++) begin
      @(negedge clk);
      check("bp_req_valid", 32'(mem.mem_req_valid), 32'd1);
      check("bp_addr", mem.mem_addr, v.pc);
      step();
    end
    mem.mem_req_ready = 1'b1;
    @(negedge clk);
    check("req_valid", 32'(mem.mem_req_valid), 32'd1);
    check("req_addr", mem.mem_addr, v.pc);
    step();
    mem.mem_req_ready = 1'b0;
    for (int i = 0; i < v.rsp_dly; i++) begin
      @(negedge clk);
      check("wait_busy", 32'(busy), 32'd1);
      check("wait_req_valid", 32'(mem.mem_req_valid), 32'd0);
      step();
    end
    mem.mem_rsp_valid = 1'b1;
    mem.mem_rsp_data  = v.data;
    exp_q.push_back(v);
    step();
    mem.mem_rsp_valid = 1'b0;
    mem.mem_rsp_data  = 32'h0;
    @(negedge clk);
    check("done_instr_valid", 32'(instr_valid), 32'd1);
    step();
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_instr_valid", 32'(instr_valid), 32'd0);
    check("pulses_per_fetch", 32'(iv_count - iv0), 32'd1);
    check("requests_per_fetch", 32'(hs_count - hs0), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   iv0;
    int   hs0;
    vec_t v;

    vecs[0] = '{32'h40, 32'h8C41_0004, 0, 0, OP_LW,    5'd2, 5'd1, 5'd0,  6'h04, 16'h0004};
    vecs[1] = '{32'h44, 32'hAC62_0008, 5, 3, OP_SW,    5'd3, 5'd2, 5'd0,  6'h08, 16'h0008};
    vecs[2] = '{32'h48, 32'h0085_1020, 1, 1, OP_RTYPE, 5'd4, 5'd5, 5'd2,  6'h20, 16'h1020};
    vecs[3] = '{32'h4C, 32'h1000_FFFF, 2, 0, OP_BEQ,   5'd0, 5'd0, 5'd31, 6'h3F, 16'hFFFF};
    vecs[4] = '{32'h50, 32'h20A5_FFFE, 0, 2, OP_ADDI,  5'd5, 5'd5, 5'd31, 6'h3E, 16'hFFFE};
    vecs[5] = '{32'h54, 32'h0800_0010, 0, 1, OP_J,     5'd0, 5'd0, 5'd0,  6'h10, 16'h0010};

    reset_n           = 1'b0;
    fetch_req         = 1'b0;
    pc                = 32'h0;
    flush             = 1'b0;
    mem.mem_req_ready = 1'b0;
    mem.mem_rsp_valid = 1'b0;
    mem.mem_rsp_data  = 32'h0;
    step();
    step();
    @(negedge clk);
    check("rst_instr", instr, RESET_IR);
    check("rst_op", 32'(op), 32'd0);
    check("rst_mem_addr", mem.mem_addr, 32'h0);
    check("rst_req_valid", 32'(mem.mem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    step();
    reset_n = 1'b1;
    step();

    // Table-driven fetches, including backpressure and varying response delay
    foreach (vecs[i]) begin
      do_fetch(vecs[i]);
      step();
    end
    check("no_err_after_table", 32'(err), 32'd0);

    // Flush in WAIT, response two cycles later: drained, IR keeps previous word
    do_fetch(vecs[0]);
    step();
    iv0 = iv_count;
    fetch_req = 1'b1;
    pc        = 32'h60;
    step();
    fetch_req         = 1'b0;
    mem.mem_req_ready = 1'b1;
    step();
    mem.mem_req_ready = 1'b0;
    flush             = 1'b1;
    step();
    @(negedge clk);
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_req_valid", 32'(mem.mem_req_valid), 32'd0);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("drain_ignores_flush", 32'(busy), 32'd1);
    step();
    mem.mem_rsp_valid = 1'b1;
    mem.mem_rsp_data  = 32'hFFFF_FFFF;
    step();
    mem.mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("drain_to_idle", 32'(busy), 32'd0);
    check("drain_ir_kept", instr, 32'h8C41_0004);
    check("drain_no_pulse", 32'(iv_count - iv0), 32'd0);
    check("drain_err", 32'(err), 32'd0);
    step();
    do_fetch(vecs[2]);
    step();

    // Flush and response together in WAIT: data dropped, straight to IDLE
    iv0 = iv_count;
    fetch_req = 1'b1;
    pc        = 32'h64;
    step();
    fetch_req         = 1'b0;
    mem.mem_req_ready = 1'b1;
    step();
    mem.mem_req_ready = 1'b0;
    flush             = 1'b1;
    mem.mem_rsp_valid = 1'b1;
    mem.mem_rsp_data  = 32'h1234_5678;
    step();
    flush             = 1'b0;
    mem.mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("flushrsp_busy", 32'(busy), 32'd0);
    check("flushrsp_ir_kept", instr, 32'h0085_1020);
    check("flushrsp_no_pulse", 32'(iv_count - iv0), 32'd0);
    check("flushrsp_err", 32'(err), 32'd0);
    step();

    // Flush in REQ alongside ready: request retracted, WAIT never entered
    fetch_req = 1'b1;
    pc        = 32'h68;
    step();
    fetch_req         = 1'b0;
    flush             = 1'b1;
    mem.mem_req_ready = 1'b1;
    step();
    flush             = 1'b0;
    mem.mem_req_ready = 1'b0;
    @(negedge clk);
    check("reqflush_req_valid", 32'(mem.mem_req_valid), 32'd0);
    check("reqflush_busy", 32'(busy), 32'd0);
    step();
    @(negedge clk);
    check("reqflush_still_idle", 32'(busy), 32'd0);
    step();
    do_fetch(vecs[3]);
    step();

    // fetch_req held through WAIT and DONE must not start a second fetch
    v    = vecs[0];
    v.pc = 32'h70;
    hs0  = hs_count;
    fetch_req = 1'b1;
    pc        = v.pc;
    step();
    fetch_req         = 1'b0;
    mem.mem_req_ready = 1'b1;
    step();
    mem.mem_req_ready = 1'b0;
    fetch_req         = 1'b1;
    pc                = 32'h74;
    step();
    mem.mem_rsp_valid = 1'b1;
    mem.mem_rsp_data  = v.data;
    exp_q.push_back(v);
    step();
    mem.mem_rsp_valid = 1'b0;
    step();
    fetch_req = 1'b0;
    @(negedge clk);
    check("ignore_req_busy", 32'(busy), 32'd0);
    check("ignore_req_valid", 32'(mem.mem_req_valid), 32'd0);
    step();
    @(negedge clk);
    check("ignore_req_still_idle", 32'(busy), 32'd0);
    check("ignore_req_one_request", 32'(hs_count - hs0), 32'd1);
    check("ignore_req_addr", mem.mem_addr, 32'h70);
    check("no_err_before_spurious", 32'(err), 32'd0);
    step();

    // Spurious response in IDLE: sticky error, cleared only by async reset
    mem.mem_rsp_valid = 1'b1;
    mem.mem_rsp_data  = 32'hBAD0_BAD0;
    step();
    mem.mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("spurious_err", 32'(err), 32'd1);
    step();
    step();
    @(negedge clk);
    check("spurious_err_sticky", 32'(err), 32'd1);
    check("spurious_ir_kept", instr, 32'h8C41_0004);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_err", 32'(err), 32'd0);
    check("async_rst_instr", instr, RESET_IR);
    step();
    reset_n = 1'b1;
    step();

    // Unaligned PC: flagged, but the fetch completes at that address
    v    = vecs[4];
    v.pc = 32'h42;
    do_fetch(v);
    check("misaligned_err", 32'(err), 32'd1);
    step();

    // Reset mid-fetch, then a stale response lands in IDLE
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    fetch_req = 1'b1;
    pc        = 32'h80;
    step();
    fetch_req = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check("midfetch_rst_busy", 32'(busy), 32'd0);
    check("midfetch_rst_req_valid", 32'(mem.mem_req_valid), 32'd0);
    check("midfetch_rst_err", 32'(err), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    mem.mem_rsp_valid = 1'b1;
    mem.mem_rsp_data  = 32'h0;
    step();
    mem.mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("stale_rsp_err", 32'(err), 32'd1);
    check("stale_rsp_busy", 32'(busy), 32'd0);
    step();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Multicycle MIPS instruction-fetch stage sitting directly upstream of the main control decoder. On a fetch request from control, it issues a word read to instruction memory over a valid/ready request channel and waits for the response. It latches the returned word into the instruction register (IR) and presents the decoded fields (op, funct, rs, rt, rd, imm) to the main and ALU decoders, with a one-cycle completion pulse. It also supports flush with in-flight response draining and a sticky protocol-error flag.

## Interface
- WIDTH, 32, data/address width
- RESET_IR, 32'h0000_0000, IR value after reset
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- fetch_req  in  1  start fetch; sampled only in IDLE
- pc  in  WIDTH  fetch address; sampled with fetch_req
- flush  in  1  abandon current fetch
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  WIDTH  registered request address
- mem_rsp_valid  in  1  read data valid
- mem_rsp_data  in  WIDTH  read data
- instr  out  WIDTH  IR contents
- op, funct  out  6 each  instr[31:26], instr[5:0]
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11]
- imm  out  16  instr[15:0]
- instr_valid  out  1  one-cycle pulse: IR just updated
- busy  out  1  state != IDLE
- err  out  1  sticky protocol error

## Operation
- States: IDLE, REQ, WAIT, DONE, DRAIN. Reset -> IDLE.
- IDLE: if fetch_req, load mem_addr <= pc -> REQ. fetch_req is ignored in every other state (no queuing).
- REQ: mem_req_valid=1. mem_addr is held stable. On mem_req_ready -> WAIT. If flush (priority over ready) -> IDLE and retract the request, with no transfer.
- WAIT: on mem_rsp_valid, IR <= mem_rsp_data -> DONE. If flush without rsp -> DRAIN. If flush and rsp occur together, the data is discarded, IR is unchanged, and the next state is IDLE.
- DONE: instr_valid=1 for exactly this cycle -> IDLE. Flush in DONE has no effect (IR already committed).
- DRAIN: wait for mem_rsp_valid, discard it -> IDLE. flush is ignored.
- mem_rsp_valid in IDLE, REQ or DONE sets err=1 until reset. The data is ignored.
- mem_addr[1:0] != 0 when loaded sets err. The fetch still proceeds with the address as given.
- IR changes only on the WAIT->DONE transition. Decoded fields are pure slices of IR.
- Reset values: IR=RESET_IR (so op=0, funct=0, etc.), mem_addr=0, mem_req_valid=0, instr_valid=0, busy=0, err=0.
- Reset mid-fetch returns to IDLE immediately. An outstanding memory response after reset counts as a protocol error only if it arrives outside WAIT/DRAIN.

## Timing
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.
- fetch_req in cycle 0 -> mem_req_valid in cycle 1.
- Ready in cycle k -> WAIT from k+1. The earliest usable rsp is in cycle k+1.
- rsp in cycle n -> instr updated and instr_valid high in cycle n+1.
- Minimum fetch_req-to-instr_valid latency is 3 cycles (ready in 1, rsp in 2).
- A back-to-back fetch_req is accepted in the cycle after DONE. Maximum throughput is one instruction per 4 cycles.

## Structure
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_ADDI=6'b001000, OP_J=6'b000010)
  - instruction field bit positions
  - the fetch state encoding, which is one-hot
- One sub-module, instr_fields: combinational IR-to-fields slicer, reused by the decoders' benches.

## Test plan
- Basic fetch: pc=0x40, ready in cycle 1, rsp 0x8C41_0004 in cycle 2 -> instr_valid in cycle 3, op=6'b100011, rs=2, rt=1, imm=0x0004, busy low in cycle 4.
- Backpressure: ready held low for 5 cycles -> mem_req_valid and mem_addr=0x44 stable throughout. Then ready=1, rsp after 3 cycles -> instr_valid exactly once.
- Flush in WAIT, rsp 2 cycles later -> state DRAIN, IR keeps previous 0x8C41_0004, no instr_valid, err=0. The next fetch succeeds.
- Flush in REQ with ready=1 in the same cycle -> mem_req_valid drops next cycle, state IDLE, no WAIT entered.
- Spurious rsp_valid in IDLE -> err=1 and stays set. reset_n low -> err=0, IR=RESET_IR asynchronously.
- fetch_req pulsed during WAIT and DONE -> ignored; only one memory request observed.
